// File: rtl/alu_seq_if.sv
// alu_seq_if -- operand/result handshake bundle for alu_seq.
//   master : producer/consumer side (drives operands, opcode, out_ready)
//   slave  : ALU side (drives in_ready, result, remainder and flags)
// Signals:
//   in_valid/in_ready   operand handshake
//   A, B, opcode        operands and operation select
//   out_valid/out_ready result handshake
//   result, remainder   operation result, DIV remainder
//   *_flag              carry, zero, negative, overflow
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] remainder;
  logic             carry_flag;
  logic             zero_flag;
  logic             negative_flag;
  logic             overflow_flag;

  modport master (
    output in_valid, A, B, opcode, out_ready,
    input  in_ready, out_valid, result, remainder,
           carry_flag, zero_flag, negative_flag, overflow_flag
  );

  modport slave (
    input  in_valid, A, B, opcode, out_ready,
    output in_ready, out_valid, result, remainder,
           carry_flag, zero_flag, negative_flag, overflow_flag
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq -- clocked WIDTH-bit ALU with valid/ready handshake.
// Single-cycle ops (add/sub/logic/shift) complete on the accept edge.
// MUL (shift-add) and DIV (restoring) iterate once per clock for WIDTH
// clocks; DIV by zero short-circuits to a single-cycle result.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  alu_seq_if.slave: operand handshake, result handshake, flags
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_NOT  = 4'b0100;
  localparam logic [3:0] OP_MUL  = 4'b0101;
  localparam logic [3:0] OP_DIV  = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_LSL  = 4'b1000;
  localparam logic [3:0] OP_LSR  = 4'b1001;
  localparam logic [3:0] OP_ASR  = 4'b1010;
  localparam logic [3:0] OP_ROL  = 4'b1011;
  localparam logic [3:0] OP_ROR  = 4'b1100;
  localparam logic [3:0] OP_ASL  = 4'b1101;
  localparam logic [3:0] OP_PASS = 4'b1111;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic             div_q, div_d;      // iterating op is DIV (else MUL)
  logic [WIDTH-1:0] opnd_q, opnd_d;    // multiplicand / divisor
  logic [WIDTH-1:0] hi_q, hi_d;        // product high half / partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;        // multiplier bits / quotient bits
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;

  logic in_ready_w;
  logic accept;

  // Ready in IDLE, or in DONE when the current result is being consumed
  // on this edge (back-to-back). Forced low while reset is asserted.
  assign in_ready_w = !rst && ((state_q == IDLE) ||
                               ((state_q == DONE) && bus.out_ready));
  assign accept     = bus.in_valid && in_ready_w;

  // ---------------------------------------------------------------
  // Single-cycle result, computed directly from the bus operands.
  // ---------------------------------------------------------------
  logic [WIDTH-1:0] sc_result, sc_rem;
  logic             sc_carry, sc_ovf;
  logic [WIDTH:0]   add_w, sub_w;

  always_comb begin
    sc_result = '0;
    sc_rem    = '0;
    sc_carry  = 1'b0;
    sc_ovf    = 1'b0;
    add_w     = {1'b0, bus.A} + {1'b0, bus.B};
    sub_w     = {1'b0, bus.A} - {1'b0, bus.B};
    case (bus.opcode)
      OP_ADD: begin
        sc_result = add_w[WIDTH-1:0];
        sc_carry  = add_w[WIDTH];
        sc_ovf    = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                    (add_w[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_SUB: begin
        sc_result = sub_w[WIDTH-1:0];
        sc_carry  = sub_w[WIDTH];      // borrow out when A < B
        sc_ovf    = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                    (sub_w[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_AND:  sc_result = bus.A & bus.B;
      OP_OR:   sc_result = bus.A | bus.B;
      OP_XOR:  sc_result = bus.A ^ bus.B;
      OP_NOT:  sc_result = ~bus.A;
      OP_PASS: sc_result = bus.A;
      // Only reached with B == 0; a zero multiplier gives a zero product.
      OP_MUL:  sc_result = '0;
      // Only reached with B == 0: divide-by-zero convention.
      OP_DIV: begin
        sc_result = '1;
        sc_rem    = bus.A;
        sc_ovf    = 1'b1;
      end
      OP_LSL: begin
        sc_result = {bus.A[WIDTH-2:0], 1'b0};
        sc_carry  = bus.A[WIDTH-1];
      end
      OP_LSR: begin
        sc_result = {1'b0, bus.A[WIDTH-1:1]};
        sc_carry  = bus.A[0];
      end
      OP_ASR: begin
        sc_result = {bus.A[WIDTH-1], bus.A[WIDTH-1:1]};
        sc_carry  = bus.A[0];
      end
      OP_ROL: begin
        sc_result = {bus.A[WIDTH-2:0], bus.A[WIDTH-1]};
        sc_carry  = bus.A[WIDTH-1];
      end
      OP_ROR: begin
        sc_result = {bus.A[0], bus.A[WIDTH-1:1]};
        sc_carry  = bus.A[0];
      end
      OP_ASL: begin
        sc_result = {bus.A[WIDTH-2:0], 1'b0};
        sc_carry  = bus.A[WIDTH-1];
        sc_ovf    = bus.A[WIDTH-1] ^ bus.A[WIDTH-2];
      end
      default: ;                        // 1110: all zero
    endcase
  end

  // ---------------------------------------------------------------
  // One iteration of the multi-cycle units.
  // MUL: {hi,lo} is shifted right each step; hi accumulates the
  //      multiplicand whenever the multiplier LSB (lo[0]) is set.
  // DIV: {hi,lo} is shifted left; the divisor is subtracted from the
  //      partial remainder when it fits, shifting a 1 into the quotient.
  // ---------------------------------------------------------------
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
  logic [WIDTH:0]   div_shift;
  logic             div_fits;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] div_hi_n, div_lo_n;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    mul_hi_n  = mul_sum[WIDTH:1];
    mul_lo_n  = {mul_sum[0], lo_q[WIDTH-1:1]};
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_fits  = div_shift >= {1'b0, opnd_q};
    // Only used when the divisor fits, so the difference is < divisor.
    div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    div_hi_n  = div_fits ? div_diff : div_shift[WIDTH-1:0];
    div_lo_n  = {lo_q[WIDTH-2:0], div_fits};
  end

  // ---------------------------------------------------------------
  // Next-state / datapath control.
  // ---------------------------------------------------------------
  logic             load_out;
  logic [WIDTH-1:0] out_res, out_rem;
  logic             out_c, out_v;

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    rem_d    = rem_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    load_out = 1'b0;
    out_res  = '0;
    out_rem  = '0;
    out_c    = 1'b0;
    out_v    = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          if (((bus.opcode == OP_MUL) || (bus.opcode == OP_DIV)) &&
              (bus.B != '0)) begin
            state_d = BUSY;
            div_d   = (bus.opcode == OP_DIV);
            opnd_d  = (bus.opcode == OP_DIV) ? bus.B : bus.A;
            lo_d    = (bus.opcode == OP_DIV) ? bus.A : bus.B;
            hi_d    = '0;
            cnt_d   = CW'(WIDTH);
          end else begin
            state_d  = DONE;
            load_out = 1'b1;
            out_res  = sc_result;
            out_rem  = sc_rem;
            out_c    = sc_carry;
            out_v    = sc_ovf;
          end
        end else if ((state_q == DONE) && bus.out_ready) begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        hi_d  = div_q ? div_hi_n : mul_hi_n;
        lo_d  = div_q ? div_lo_n : mul_lo_n;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d  = DONE;
          load_out = 1'b1;
          if (div_q) begin
            out_res = div_lo_n;
            out_rem = div_hi_n;
          end else begin
            out_res = mul_lo_n;
            out_c   = (mul_hi_n != '0);
            out_v   = (mul_hi_n != '0);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs only ever change on the edge that enters DONE.
    if (load_out) begin
      result_d = out_res;
      rem_d    = out_rem;
      carry_d  = out_c;
      ovf_d    = out_v;
      zero_d   = (out_res == '0);
      neg_d    = out_res[WIDTH-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= 1'b0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      rem_q    <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      div_q    <= div_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.in_ready      = in_ready_w;
  assign bus.out_valid     = (state_q == DONE);
  assign bus.result        = result_q;
  assign bus.remainder     = rem_q;
  assign bus.carry_flag    = carry_q;
  assign bus.zero_flag     = zero_q;
  assign bus.negative_flag = neg_q;
  assign bus.overflow_flag = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  alu_seq_if #(.WIDTH(8)) bus ();

  alu_seq #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  // lat = number of clock edges after the accept edge at which out_valid
  // is first seen high (0 = visible right after the accept edge).
  typedef struct {
    string    name;
    logic [19:0] exp;   // {result, remainder, carry, zero, negative, overflow}
    int       lat;
    int       acc;
  } exp_t;

  exp_t sb[$];

  function automatic logic [19:0] cur_out();
    return {bus.result, bus.remainder, bus.carry_flag, bus.zero_flag,
            bus.negative_flag, bus.overflow_flag};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic [19:0] held;
  bit          presented = 0;

  always @(negedge clk) begin
    if (rst) begin
      presented = 0;
    end else if (bus.out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output got=%h expected none", cur_out());
      end else begin
        if (!presented) begin
          checks++;
          if (cycle - sb[0].acc != sb[0].lat) begin
            errors++;
            $display("FAIL %s latency got=%0d expected=%0d",
                     sb[0].name, cycle - sb[0].acc, sb[0].lat);
          end
          checks++;
          if (cur_out() !== sb[0].exp) begin
            errors++;
            $display("FAIL %s res/rem/c/z/n/v got=%h/%h/%b%b%b%b expected=%h/%h/%b%b%b%b",
                     sb[0].name, cur_out()[19:12], cur_out()[11:4], cur_out()[3],
                     cur_out()[2], cur_out()[1], cur_out()[0],
                     sb[0].exp[19:12], sb[0].exp[11:4], sb[0].exp[3],
                     sb[0].exp[2], sb[0].exp[1], sb[0].exp[0]);
          end else begin
            $display("ok   %s result=%h rem=%h cznv=%b", sb[0].name,
                     bus.result, bus.remainder, cur_out()[3:0]);
          end
          held      = cur_out();
          presented = 1;
        end else begin
          checks++;
          if (cur_out() !== held) begin
            errors++;
            $display("FAIL %s hold got=%h expected=%h", sb[0].name, cur_out(), held);
          end
        end
        if (bus.out_ready) begin
          void'(sb.pop_front());
          presented = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called a little after a rising edge; returns 1 time unit after the
  // accept edge with the expected response queued.
  task automatic issue(input string name, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] op, input logic [7:0] res, input logic [7:0] rem,
                       input logic c, input logic z, input logic n, input logic v,
                       input int lat);
    int   w;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.A        = a;
    bus.B        = b;
    bus.opcode   = op;
    w = 0;
    #1;
    while (!bus.in_ready && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s in_ready_timeout got=0 expected=1", name);
    end
    @(posedge clk);
    #1;
    e.name = name;
    e.exp  = {res, rem, c, z, n, v};
    e.lat  = lat;
    e.acc  = cycle;
    sb.push_back(e);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got=%0d pending expected=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.opcode    = '0;
    bus.out_ready = 1'b1;
    #3;
    chk("reset_in_ready",  {7'd0, bus.in_ready}, 8'h00);
    chk("reset_out_valid", {7'd0, bus.out_valid}, 8'h00);
    chk("reset_result",    bus.result, 8'h00);
    chk("reset_flags",     {4'd0, cur_out()[3:0]}, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_reset_in_ready", {7'd0, bus.in_ready}, 8'h01);

    //     name        A      B      op      res    rem    c  z  n  v  lat
    issue("ADD_7F_01", 8'h7F, 8'h01, 4'b0000, 8'h80, 8'h00, 0, 0, 1, 1, 0);
    issue("ADD_FF_01", 8'hFF, 8'h01, 4'b0000, 8'h00, 8'h00, 1, 1, 0, 0, 0);
    drain();

    issue("MUL_10_10", 8'h10, 8'h10, 4'b0101, 8'h00, 8'h00, 1, 1, 0, 1, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("MUL_busy_in_ready_%0d", i + 1), {7'd0, bus.in_ready}, 8'h00);
      @(posedge clk);
      #1;
    end
    drain();
    issue("MUL_0C_0A", 8'h0C, 8'h0A, 4'b0101, 8'h78, 8'h00, 0, 0, 0, 0, 8);
    issue("MUL_FF_FF", 8'hFF, 8'hFF, 4'b0101, 8'h01, 8'h00, 1, 0, 0, 1, 8);
    issue("DIV_C8_07", 8'hC8, 8'h07, 4'b0110, 8'h1C, 8'h04, 0, 0, 0, 0, 8);
    issue("DIV_05_00", 8'h05, 8'h00, 4'b0110, 8'hFF, 8'h05, 0, 0, 1, 1, 0);
    issue("DIV_07_09", 8'h07, 8'h09, 4'b0110, 8'h00, 8'h07, 0, 1, 0, 0, 8);
    drain();

    // Hold result for 5 cycles, then consume and accept on the same edge.
    bus.out_ready = 1'b0;
    issue("ROR_81",    8'h81, 8'h00, 4'b1100, 8'hC0, 8'h00, 1, 0, 1, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    issue("ASR_80",    8'h80, 8'h00, 4'b1010, 8'hC0, 8'h00, 0, 0, 1, 0, 0);
    #1;
    chk("b2b_out_valid", {7'd0, bus.out_valid}, 8'h01);
    drain();

    issue("UNDEF_33",  8'h33, 8'h55, 4'b1110, 8'h00, 8'h00, 0, 1, 0, 0, 0);
    issue("SUB_08_0A", 8'h08, 8'h0A, 4'b0001, 8'hFE, 8'h00, 1, 0, 1, 0, 0);
    issue("XOR_F0_3C", 8'hF0, 8'h3C, 4'b0111, 8'hCC, 8'h00, 0, 0, 1, 0, 0);
    issue("AND_F0_3C", 8'hF0, 8'h3C, 4'b0010, 8'h30, 8'h00, 0, 0, 0, 0, 0);
    issue("OR_0F_30",  8'h0F, 8'h30, 4'b0011, 8'h3F, 8'h00, 0, 0, 0, 0, 0);
    issue("NOT_5A",    8'h5A, 8'h00, 4'b0100, 8'hA5, 8'h00, 0, 0, 1, 0, 0);
    issue("PASS_80",   8'h80, 8'h11, 4'b1111, 8'h80, 8'h00, 0, 0, 1, 0, 0);
    issue("ASL_40",    8'h40, 8'h00, 4'b1101, 8'h80, 8'h00, 0, 0, 1, 1, 0);
    issue("LSL_81",    8'h81, 8'h00, 4'b1000, 8'h02, 8'h00, 1, 0, 0, 0, 0);
    issue("LSR_01",    8'h01, 8'h00, 4'b1001, 8'h00, 8'h00, 1, 1, 0, 0, 0);
    issue("ROL_81",    8'h81, 8'h00, 4'b1011, 8'h03, 8'h00, 1, 0, 0, 0, 0);
    drain();

    // Asynchronous reset three cycles into a MUL: in-flight op discarded.
    issue("MUL_abort", 8'h10, 8'h10, 4'b0101, 8'h00, 8'h00, 1, 1, 0, 1, 8);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    chk("async_rst_out_valid", {7'd0, bus.out_valid}, 8'h00);
    chk("async_rst_in_ready",  {7'd0, bus.in_ready}, 8'h00);
    chk("async_rst_result",    bus.result, 8'h00);
    chk("async_rst_remainder", bus.remainder, 8'h00);
    chk("async_rst_flags",     {4'd0, cur_out()[3:0]}, 8'h00);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("release_in_ready", {7'd0, bus.in_ready}, 8'h01);
    issue("ADD_03_04", 8'h03, 8'h04, 4'b0000, 8'h07, 8'h00, 0, 0, 0, 0, 0);
    drain();
    repeat (2) @(posedge clk);
    #1;
    chk("end_out_valid", {7'd0, bus.out_valid}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, clocked successor to the team's 4-bit combinational ALU.
- Same opcode map and the same four flags, but generalised to WIDTH bits.
- Wrapped in a valid/ready handshake with registered outputs.
- MUL and DIV are multi-cycle iterative units (shift-add, restoring division); DIV also returns a remainder.
- Sits between the operand-fetch stage and the writeback register in the datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 4..32.

Ports:
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand/opcode presented
- in_ready  output  1  block can accept an operation this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- opcode  input  4  operation select
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  operation result
- remainder  output  WIDTH  DIV remainder; 0 for all other ops
- carry_flag  output  1  carry/borrow/shifted-out bit
- zero_flag  output  1  result == 0
- negative_flag  output  1  result[WIDTH-1]
- overflow_flag  output  1  signed overflow, MUL high-half non-zero, or divide-by-zero

Behaviour:
- Reset is asynchronous, active-high.
  - While rst=1: state=IDLE, in_ready=0, out_valid=0; result, remainder and all flags are 0.
  - After release: in_ready=1.
  - Reset mid-operation discards the in-flight op with no output.
- FSM has three states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch A, B and opcode.
    - Single-cycle ops go to DONE; out_valid=1 after that same edge (latency 1).
    - MUL/DIV with B!=0 go to BUSY with an iteration counter of WIDTH.
    - DIV with B==0 goes directly to DONE (latency 1).
  - BUSY: one iteration per edge; in_ready=0; input changes are ignored. After the WIDTH-th iteration, go to DONE. out_valid rises exactly WIDTH cycles after the accept edge.
  - DONE: out_valid=1; result, remainder and flags are held stable until out_ready=1.
    - in_ready = out_ready, so a new op can be accepted on the same edge the result is consumed (back-to-back).
    - If no new op is accepted, go to IDLE and set out_valid=0.
- Opcodes (B is unused for unary and shift ops; all shifts are by 1):
  - 0000 ADD: {carry,result}=A+B; overflow = signed overflow.
  - 0001 SUB: result=A-B; carry=1 when A<B unsigned (borrow); overflow = signed overflow.
  - 0010 AND, 0011 OR, 0111 XOR, 0100 NOT A, 1111 PASS A: carry=0, overflow=0.
  - 0101 MUL (unsigned): result = low WIDTH bits of the 2*WIDTH product; carry=overflow=1 if the high half is non-zero.
  - 0110 DIV (unsigned): result=quotient, remainder=A mod B, carry=0, overflow=0.
    - B==0: result=all ones, remainder=A, overflow=1.
  - 1000 LSL: carry=A[WIDTH-1]; overflow=0.
  - 1001 LSR: carry=A[0]; overflow=0.
  - 1010 ASR: MSB replicated; carry=A[0]; overflow=0.
  - 1011 ROL: carry=A[WIDTH-1]; overflow=0.
  - 1100 ROR: carry=A[0]; overflow=0.
  - 1101 ASL: as LSL, plus overflow=A[WIDTH-1]^A[WIDTH-2].
  - 1110 (undefined): result=0, carry=0, overflow=0.
- For every op: zero_flag=(result==0) and negative_flag=result[WIDTH-1], both computed from the final registered result.
- remainder=0 for every opcode except DIV.
- Outputs change only on the edge that loads DONE, or asynchronously on reset. They must never toggle while out_valid=1 and out_ready=0.

Test Plan (WIDTH=8):
- ADD 0x7F+0x01 -> one cycle after accept: result=0x80, negative=1, overflow=1, carry=0, zero=0. ADD 0xFF+0x01 -> result=0x00, carry=1, zero=1.
- MUL 0x10*0x10 -> in_ready=0 for cycles 1..8; out_valid exactly 8 cycles after accept; result=0x00, carry=1, overflow=1, zero=1. MUL 0x0C*0x0A -> result=0x78, carry=0, overflow=0.
- DIV 200/7 -> after 8 cycles: result=0x1C, remainder=0x04. DIV 5/0 -> after 1 cycle: result=0xFF, remainder=0x05, overflow=1, negative=1.
- ROR 0x81 with out_ready=0 for 5 cycles -> result=0xC0 and carry=1 held stable throughout. Then out_ready=1 with in_valid=1 (ASR 0x80) on the same edge -> next cycle: result=0xC0, carry=0, out_valid still 1.
- Opcode 1110, A=0x33 -> result=0x00, zero=1, carry=0, overflow=0. SUB 0x08-0x0A -> result=0xFE, carry=1, negative=1, overflow=0.
- Assert rst asynchronously 3 cycles into a MUL -> out_valid, in_ready, result, remainder and all flags go to 0 immediately. After release, ADD 0x03+0x04 -> result=0x07, latency 1.
